// File: rtl/mcycle_sequencer_pkg.sv
// mcycle_sequencer_pkg: condition codes, CB prefix and flag positions shared by the
// sequencer and its decoder.
package mcycle_sequencer_pkg;
    typedef enum logic [1:0] {NZ, Z, NC, C} cc_t;
    localparam logic [7:0] CB_PREFIX = 8'hCB;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 0;
    function automatic logic cc_met(input cc_t cc, input logic [3:0] flags);
        return cc == NZ ? !flags[FLAG_Z] :
               cc == Z  ?  flags[FLAG_Z] :
               cc == NC ? !flags[FLAG_C] : flags[FLAG_C];
    endfunction
endpackage

// File: rtl/mcycle_sequencer_irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder over the interrupt request lines.
module irq_prio_enc #(
    parameter int NUM_IRQ = 5,
    parameter int IDX_W = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_IRQ-1:0] onehot,
    output logic               any
);
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (req[i]) idx = IDX_W'(i);
    end
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + NUM_IRQ'(1));
    assign any    = |req;
endmodule

// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: instruction register, M-cycle step counter and control-flow state
// (CB page, interrupt dispatch, HALT) feeding the combinational opcode decoder.
module mcycle_sequencer
    import mcycle_sequencer_pkg::*;
#(
    parameter int         STEP_W     = 3,
    parameter int         NUM_IRQ    = 5,
    parameter logic [7:0] VEC_BASE   = 8'h40,
    parameter int         VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [7:0]         mem_rdata,
    input  logic               done,
    input  logic               is_cond,
    input  logic [STEP_W-1:0]  next_cond,
    input  logic [3:0]         flags,
    input  logic               ime,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               halt_req,
    output logic [7:0]         opcode,
    output logic [STEP_W-1:0]  step,
    output logic               cb_mode,
    output logic               irq_active,
    output logic [7:0]         irq_vector,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               halted,
    output logic               seq_err
);
    localparam int IDX_W = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;

    logic [IDX_W-1:0]   irq_idx;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic               irq_any;
    logic [7:0]         opcode_d, vec_d, vec_sel;
    logic [STEP_W-1:0]  step_d;
    logic [NUM_IRQ-1:0] ack_d;
    logic               cb_d, act_d, halt_d, err_d, take_irq;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
        .req(irq_req), .idx(irq_idx), .onehot(irq_onehot), .any(irq_any)
    );

    assign vec_sel  = 8'(int'(VEC_BASE) + VEC_STRIDE * int'(irq_idx));
    // A CB prefix and its second byte form one instruction; never split them.
    assign take_irq = !irq_active && ime && irq_any && !(opcode == CB_PREFIX && !cb_mode);

    always_comb begin
        opcode_d = opcode;
        step_d   = step;
        cb_d     = cb_mode;
        act_d    = irq_active;
        vec_d    = irq_vector;
        ack_d    = '0;
        halt_d   = halted;
        err_d    = seq_err;
        if (stall || (halted && !irq_any)) begin
        end else if (done || halted) begin
            step_d = '0;
            halt_d = 1'b0;
            if (take_irq) begin
                act_d = 1'b1;
                ack_d = irq_onehot;
                vec_d = vec_sel;
            end else if (halt_req && !halted) begin
                halt_d = 1'b1;
            end else begin
                opcode_d = mem_rdata;
                act_d    = 1'b0;
                cb_d     = opcode == CB_PREFIX && !cb_mode;
            end
        end else if (is_cond) begin
            step_d = cc_met(cc_t'(opcode[4:3]), flags) ? step + 1'b1 : next_cond;
        end else begin
            step_d = step + 1'b1;
            err_d  = seq_err || &step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode     <= 8'h00;
            step       <= '0;
            cb_mode    <= 1'b0;
            irq_active <= 1'b0;
            irq_vector <= VEC_BASE;
            irq_ack    <= '0;
            halted     <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            opcode     <= opcode_d;
            step       <= step_d;
            cb_mode    <= cb_d;
            irq_active <= act_d;
            irq_vector <= vec_d;
            irq_ack    <= ack_d;
            halted     <= halt_d;
            seq_err    <= err_d;
        end
    end
endmodule

// File: tb/tb_mcycle_sequencer.sv
// tb_mcycle_sequencer: directed vector table, reset-abort sequence and randomized run
// against a behavioural model of the sequencing rules.
module tb_mcycle_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       stall = 0, done = 0, is_cond = 0, ime = 0, halt_req = 0;
    logic [7:0] mem_rdata = 0;
    logic [2:0] next_cond = 0;
    logic [3:0] flags = 0;
    logic [4:0] irq_req = 0;
    logic [7:0] opcode, irq_vector;
    logic [2:0] step;
    logic [4:0] irq_ack;
    logic       cb_mode, irq_active, halted, seq_err;

    int n_chk = 0, n_fail = 0;

    mcycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .mem_rdata(mem_rdata), .done(done),
        .is_cond(is_cond), .next_cond(next_cond), .flags(flags), .ime(ime),
        .irq_req(irq_req), .halt_req(halt_req), .opcode(opcode), .step(step),
        .cb_mode(cb_mode), .irq_active(irq_active), .irq_vector(irq_vector),
        .irq_ack(irq_ack), .halted(halted), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, dn, ic;
        logic [2:0] nc;
        logic [3:0] fl;
        logic       im;
        logic [4:0] iq;
        logic       hr;
        logic [7:0] rd;
        logic [7:0] op;
        logic [2:0] sp;
        logic       cb, act;
        logic [7:0] vec;
        logic [4:0] ack;
        logic       hl, err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, dn, ic, input logic [2:0] nc, input logic [3:0] fl,
                                input logic im, input logic [4:0] iq, input logic hr, input logic [7:0] rd,
                                input logic [7:0] op, input logic [2:0] sp, input logic cb, act,
                                input logic [7:0] vec, input logic [4:0] ack, input logic hl, err);
        vec_t v;
        v.st = st; v.dn = dn; v.ic = ic; v.nc = nc; v.fl = fl; v.im = im; v.iq = iq; v.hr = hr;
        v.rd = rd; v.op = op; v.sp = sp; v.cb = cb; v.act = act; v.vec = vec; v.ack = ack;
        v.hl = hl; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] op, input logic [2:0] sp,
                             input logic cb, act, input logic [7:0] vec, input logic [4:0] ack,
                             input logic hl, err);
        chk({tag, ".opcode"}, 32'(opcode), 32'(op));
        chk({tag, ".step"}, 32'(step), 32'(sp));
        chk({tag, ".cb_mode"}, 32'(cb_mode), 32'(cb));
        chk({tag, ".irq_active"}, 32'(irq_active), 32'(act));
        chk({tag, ".irq_vector"}, 32'(irq_vector), 32'(vec));
        chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(ack));
        chk({tag, ".halted"}, 32'(halted), 32'(hl));
        chk({tag, ".seq_err"}, 32'(seq_err), 32'(err));
    endtask

    // Behavioural model: one cycle of the sequencing rules, evaluated in priority order.
    logic [7:0] m_op, m_vec;
    int         m_step, m_ack;
    bit         m_cb, m_act, m_halt, m_err;

    task automatic model_reset();
        m_op = 8'h00; m_vec = 8'h40; m_step = 0; m_ack = 0;
        m_cb = 0; m_act = 0; m_halt = 0; m_err = 0;
    endtask

    task automatic model_step();
        int  new_ack = 0;
        bit  wake = m_halt && irq_req != 0;
        bit  taken;
        if (stall || (m_halt && irq_req == 0)) begin
        end else if (done || wake) begin
            m_step = 0;
            m_halt = 0;
            if (!m_act && ime && irq_req != 0 && !(m_op == 8'hCB && !m_cb)) begin
                int k = 0;
                while (!irq_req[k]) k++;
                m_act = 1;
                new_ack = 1 << k;
                m_vec = 8'((64 + 8 * k) % 256);
            end else if (halt_req && !wake) begin
                m_halt = 1;
            end else begin
                m_cb = m_op == 8'hCB && !m_cb;
                m_op = mem_rdata;
                m_act = 0;
            end
        end else if (is_cond) begin
            case (m_op[4:3])
                2'd0: taken = !flags[3];
                2'd1: taken = flags[3];
                2'd2: taken = !flags[0];
                default: taken = flags[0];
            endcase
            m_step = taken ? (m_step + 1) % 8 : int'(next_cond);
        end else begin
            if (m_step == 7) m_err = 1;
            m_step = (m_step + 1) % 8;
        end
        m_ack = new_ack;
    endtask

    initial begin
        //        st dn ic nc  flags     ime irq       hr rdata   op     sp cb act vec    ack       hl err
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h00, 2, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h00, 3, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h3E, 8'h3E, 0, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h20, 8'h20, 0, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h20, 1, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 4, 4'b1000, 0, 5'b00000, 0, 8'h00, 8'h20, 4, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h20, 8'h20, 0, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h20, 1, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 4, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h20, 2, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'hCB, 8'hCB, 0, 0, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 5'b00001, 0, 8'h37, 8'h37, 0, 1, 0, 8'h40, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 5'b10100, 0, 8'h00, 8'h37, 0, 1, 1, 8'h50, 5'b00100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 5'b10100, 0, 8'h00, 8'h37, 1, 1, 1, 8'h50, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 5'b10100, 0, 8'hAF, 8'hAF, 0, 0, 0, 8'h50, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 5'b00000, 1, 8'h11, 8'hAF, 0, 0, 0, 8'h50, 5'b00000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h11, 8'hAF, 0, 0, 0, 8'h50, 5'b00000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00001, 0, 8'h12, 8'h12, 0, 0, 0, 8'h50, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h12, 1, 0, 0, 8'h50, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h12, 1, 0, 0, 8'h50, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h55, 8'h12, 1, 0, 0, 8'h50, 5'b00000, 0, 0));
        for (int s = 2; s <= 7; s++)
            tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h12, 3'(s), 0, 0, 8'h50, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h12, 0, 0, 0, 8'h50, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 8'h50, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 5'b00000, 1, 8'h00, 8'h00, 0, 0, 0, 8'h50, 5'b00000, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 5'b01000, 0, 8'h99, 8'h00, 0, 0, 1, 8'h58, 5'b01000, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 1, 8'h58, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 5'b00010, 0, 8'h77, 8'h77, 0, 0, 0, 8'h58, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 5'b00010, 0, 8'h00, 8'h77, 0, 0, 1, 8'h48, 5'b00010, 0, 1));

        #12;
        check_all("reset", 8'h00, 0, 0, 0, 8'h40, 5'b00000, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            stall = tbl[i].st; done = tbl[i].dn; is_cond = tbl[i].ic; next_cond = tbl[i].nc;
            flags = tbl[i].fl; ime = tbl[i].im; irq_req = tbl[i].iq; halt_req = tbl[i].hr;
            mem_rdata = tbl[i].rd;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), tbl[i].op, tbl[i].sp, tbl[i].cb, tbl[i].act,
                      tbl[i].vec, tbl[i].ack, tbl[i].hl, tbl[i].err);
        end

        // Reset asserted mid-op, between clock edges, must take effect at once.
        stall = 0; is_cond = 0; ime = 0; irq_req = 0; halt_req = 0;
        done = 1; mem_rdata = 8'h3E;
        @(posedge clk); #1;
        done = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("pre_rst", 8'h3E, 2, 0, 0, 8'h48, 5'b00000, 0, 1);
        #2 rst_n = 1'b0;
        #1 check_all("rst_async", 8'h00, 0, 0, 0, 8'h40, 5'b00000, 0, 0);
        @(posedge clk); #1;
        check_all("rst_hold", 8'h00, 0, 0, 0, 8'h40, 5'b00000, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check_all("rst_release", 8'h00, 0, 0, 0, 8'h40, 5'b00000, 0, 0);
        @(posedge clk); #1;
        check_all("first_nop", 8'h00, 1, 0, 0, 8'h40, 5'b00000, 0, 0);

        model_reset();
        m_step = 1;
        for (int c = 0; c < 3000; c++) begin
            stall     = ($urandom % 8) == 0;
            done      = ($urandom % 3) == 0;
            is_cond   = ($urandom % 4) == 0;
            next_cond = 3'($urandom);
            flags     = 4'($urandom);
            ime       = 1'($urandom);
            irq_req   = ($urandom % 4) == 0 ? 5'($urandom) : 5'b00000;
            halt_req  = ($urandom % 6) == 0;
            mem_rdata = ($urandom % 4) == 0 ? 8'hCB : 8'($urandom);
            model_step();
            @(posedge clk); #1;
            check_all($sformatf("rnd%0d", c), m_op, 3'(m_step), m_cb, m_act, m_vec, 5'(m_ack), m_halt, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
